// File: rtl/ad9643_test_pattern_gen.sv
// AD9643 test-pattern generator: produces test-mode sample streams or
// passes live ADC codes, paced by the clock-divide ratio.
module ad9643_test_pattern_gen #(
    parameter int unsigned DW        = 14,
    parameter logic [22:0] PN23_SEED = 23'h7FFFFF,
    parameter logic [8:0]  PN9_SEED  = 9'h1FF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    test_mode,
    input  logic [7:0]    clock_divide,
    input  logic [15:0]   UserTestPattern1,
    input  logic [15:0]   UserTestPattern2,
    input  logic [15:0]   UserTestPattern3,
    input  logic [15:0]   UserTestPattern4,
    input  logic          transfer_reg,
    input  logic [DW-1:0] adc_in_a,
    input  logic [DW-1:0] adc_in_b,
    output logic [DW-1:0] dout_a,
    output logic [DW-1:0] dout_b,
    output logic          sample_valid
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned MODE_W = 4;

    logic [CNT_W-1:0]  r_cnt;
    logic [MODE_W-1:0] r_last_mode;
    logic              r_chk_phase;
    logic              r_tog_phase;
    logic [22:0]       r_pn23;
    logic [8:0]        r_pn9;
    logic [1:0]        r_ptr;
    logic              r_single_done;

    logic [MODE_W-1:0] w_mode;
    logic              w_restart;
    logic              w_tick;
    logic [13:0]       w_user_word;
    logic [DW-1:0]     w_sample_a;
    logic [DW-1:0]     w_sample_b;
    logic              w_unused;

    assign w_mode    = test_mode[MODE_W-1:0];
    // A mode change behaves like a shadow transfer: the pattern starts over.
    assign w_restart = transfer_reg | (w_mode != r_last_mode);
    // >= compare so a ratio shrink mid-count ticks at once instead of locking up.
    assign w_tick    = ~w_restart & (r_cnt >= clock_divide[CNT_W-1:0]);

    // Bits that are accepted on the ports but carry no meaning here.
    assign w_unused = &{1'b0, clock_divide[7:3], test_mode[6:4],
                        UserTestPattern1[1:0], UserTestPattern2[1:0],
                        UserTestPattern3[1:0], UserTestPattern4[1:0]};

    // Select the user word addressed by the sequence pointer (read live).
    always_comb begin
        w_user_word = UserTestPattern1[15:2];
        case (r_ptr)
            2'd0: w_user_word = UserTestPattern1[15:2];
            2'd1: w_user_word = UserTestPattern2[15:2];
            2'd2: w_user_word = UserTestPattern3[15:2];
            2'd3: w_user_word = UserTestPattern4[15:2];
            default: w_user_word = UserTestPattern1[15:2];
        endcase
    end

    // Sample value presented at the next tick for the active mode.
    always_comb begin
        w_sample_a = '0;
        w_sample_b = '0;
        case (w_mode)
            4'd0: begin
                w_sample_a = adc_in_a;
                w_sample_b = adc_in_b;
            end
            4'd1: w_sample_a = DW'(14'h2000);
            4'd2: w_sample_a = DW'(14'h3FFF);
            4'd3: w_sample_a = DW'(14'h0000);
            4'd4: w_sample_a = r_chk_phase ? DW'(14'h1555) : DW'(14'h2AAA);
            4'd5: w_sample_a = DW'(r_pn23[22:9]);
            4'd6: w_sample_a = DW'({r_pn9, 5'b0});
            4'd7: w_sample_a = r_tog_phase ? DW'(14'h0000) : DW'(14'h3FFF);
            4'd8: w_sample_a = r_single_done ? DW'(14'h0000) : DW'(w_user_word);
            default: w_sample_a = '0;
        endcase
        if (w_mode != 4'd0) begin
            w_sample_b = w_sample_a;
        end
    end

    // Clock-divide counter and last-mode tracker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_last_mode <= '0;
        end else begin
            r_last_mode <= w_mode;
            if (w_restart || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Pattern state: reinit on restart, advance only on tick of its own mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chk_phase   <= 1'b0;
            r_tog_phase   <= 1'b0;
            r_pn23        <= PN23_SEED;
            r_pn9         <= PN9_SEED;
            r_ptr         <= '0;
            r_single_done <= 1'b0;
        end else if (w_restart) begin
            r_chk_phase   <= 1'b0;
            r_tog_phase   <= 1'b0;
            r_pn23        <= PN23_SEED;
            r_pn9         <= PN9_SEED;
            r_ptr         <= '0;
            r_single_done <= 1'b0;
        end else if (w_tick) begin
            case (w_mode)
                4'd4: r_chk_phase <= ~r_chk_phase;
                4'd5: r_pn23      <= {r_pn23[21:0], r_pn23[22] ^ r_pn23[17]};
                4'd6: r_pn9       <= {r_pn9[7:0], r_pn9[8] ^ r_pn9[4]};
                4'd7: r_tog_phase <= ~r_tog_phase;
                4'd8: begin
                    if (!r_single_done) begin
                        r_ptr <= r_ptr + 2'd1;
                        if ((r_ptr == 2'd3) && test_mode[7]) begin
                            r_single_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers: load on tick, hold otherwise; strobe follows tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_a       <= '0;
            dout_b       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= w_tick;
            if (w_tick) begin
                dout_a <= w_sample_a;
                dout_b <= w_sample_b;
            end
        end
    end

endmodule

// File: tb/tb_ad9643_test_pattern_gen.sv
// Directed bench for ad9643_test_pattern_gen.
module tb_ad9643_test_pattern_gen;

    logic        clk;
    logic        reset;
    logic [7:0]  test_mode;
    logic [7:0]  clock_divide;
    logic [15:0] utp1, utp2, utp3, utp4;
    logic        transfer_reg;
    logic [13:0] adc_in_a, adc_in_b;
    logic [13:0] dout_a, dout_b;
    logic        sample_valid;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_a;
    logic [13:0] exp_b;

    ad9643_test_pattern_gen dut (
        .clk              (clk),
        .reset            (reset),
        .test_mode        (test_mode),
        .clock_divide     (clock_divide),
        .UserTestPattern1 (utp1),
        .UserTestPattern2 (utp2),
        .UserTestPattern3 (utp3),
        .UserTestPattern4 (utp4),
        .transfer_reg     (transfer_reg),
        .adc_in_a         (adc_in_a),
        .adc_in_b         (adc_in_b),
        .dout_a           (dout_a),
        .dout_b           (dout_b),
        .sample_valid     (sample_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {14'h0, 14'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got a=%h b=%h v=%b want 0 0 0", dout_a, dout_b, sample_valid);
        end
        reset = 1'b1;
        test_mode = 8'h02;
        clock_divide = 8'h00;
        repeat (4) step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {14'h3FFF, 14'h3FFF, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_run got a=%h b=%h v=%b want 3fff 3fff 1", dout_a, dout_b, sample_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {14'h0, 14'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got a=%h b=%h v=%b want 0 0 0", dout_a, dout_b, sample_valid);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {14'h0, 14'h0, 1'b0}) begin
            errors++;
            $display("FAIL release_clk1 got a=%h b=%h v=%b want 0 0 0", dout_a, dout_b, sample_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {14'h3FFF, 14'h3FFF, 1'b1}) begin
                errors++;
                $display("FAIL release_clk%0d got a=%h b=%h v=%b want 3fff 3fff 1", i + 2, dout_a, dout_b, sample_valid);
            end
        end
        exp_a = 14'h3FFF;
        exp_b = 14'h3FFF;
    endtask

    task automatic test_checker();
        int n;
        logic exp_v;
        n = 0;
        test_mode = 8'h04;
        clock_divide = 8'h03;
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL chk_restart got a=%h b=%h v=%b want %h %h 0", dout_a, dout_b, sample_valid, exp_a, exp_b);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_v = ((i % 4) == 0);
            if (exp_v) begin
                exp_a = (n % 2 == 0) ? 14'h2AAA : 14'h1555;
                exp_b = exp_a;
                n++;
            end
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, exp_v}) begin
                errors++;
                $display("FAIL chk_clk%0d got a=%h b=%h v=%b want %h %h %b", i, dout_a, dout_b, sample_valid, exp_a, exp_b, exp_v);
            end
        end
    endtask

    task automatic test_user();
        test_mode = 8'h08;
        clock_divide = 8'h00;
        utp1 = 16'h0004;
        utp2 = 16'h0008;
        utp3 = 16'h000C;
        utp4 = 16'h0010;
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL user_restart got a=%h b=%h v=%b want %h %h 0", dout_a, dout_b, sample_valid, exp_a, exp_b);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            exp_a = 14'((i % 4) + 1);
            exp_b = exp_a;
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b1}) begin
                errors++;
                $display("FAIL user_loop%0d got a=%h b=%h v=%b want %h %h 1", i, dout_a, dout_b, sample_valid, exp_a, exp_b);
            end
        end
        transfer_reg = 1'b1;
        test_mode = 8'h88;
        step();
        transfer_reg = 1'b0;
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL user_xfer got a=%h b=%h v=%b want %h %h 0", dout_a, dout_b, sample_valid, exp_a, exp_b);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            exp_a = (i < 4) ? 14'(i + 1) : 14'h0000;
            exp_b = exp_a;
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b1}) begin
                errors++;
                $display("FAIL user_single%0d got a=%h b=%h v=%b want %h %h 1", i, dout_a, dout_b, sample_valid, exp_a, exp_b);
            end
        end
        transfer_reg = 1'b1;
        step();
        transfer_reg = 1'b0;
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {14'h0, 14'h0, 1'b0}) begin
            errors++;
            $display("FAIL user_rexfer got a=%h b=%h v=%b want 0 0 0", dout_a, dout_b, sample_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            exp_a = 14'(i + 1);
            exp_b = exp_a;
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b1}) begin
                errors++;
                $display("FAIL user_again%0d got a=%h b=%h v=%b want %h %h 1", i, dout_a, dout_b, sample_valid, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_pn();
        logic b9  [0:28];
        logic b23 [0:36];
        for (int k = 0; k < 9; k++) b9[k] = 1'b1;
        for (int k = 9; k < 29; k++) b9[k] = b9[k-9] ^ b9[k-5];
        for (int k = 0; k < 23; k++) b23[k] = 1'b1;
        for (int k = 23; k < 37; k++) b23[k] = b23[k-23] ^ b23[k-18];
        test_mode = 8'h06;
        clock_divide = 8'h00;
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL pn9_restart got a=%h b=%h v=%b want %h %h 0", dout_a, dout_b, sample_valid, exp_a, exp_b);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            exp_a = '0;
            for (int j = 0; j < 9; j++) exp_a[13-j] = b9[i+j];
            exp_b = exp_a;
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b1}) begin
                errors++;
                $display("FAIL pn9_s%0d got a=%h b=%h v=%b want %h %h 1", i, dout_a, dout_b, sample_valid, exp_a, exp_b);
            end
        end
        test_mode = 8'h05;
        step();
        checks++;
        if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL pn23_restart got a=%h b=%h v=%b want %h %h 0", dout_a, dout_b, sample_valid, exp_a, exp_b);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            for (int j = 0; j < 14; j++) exp_a[13-j] = b23[i+j];
            exp_b = exp_a;
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, 1'b1}) begin
                errors++;
                $display("FAIL pn23_s%0d got a=%h b=%h v=%b want %h %h 1", i, dout_a, dout_b, sample_valid, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        test_mode = 8'h01;
        clock_divide = 8'h03;
        for (int i = 0; i <= 7; i++) begin
            step();
            exp_v = (i == 4);
            if (exp_v) begin
                exp_a = 14'h2000;
                exp_b = 14'h2000;
            end
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, exp_v}) begin
                errors++;
                $display("FAIL mid_clk%0d got a=%h b=%h v=%b want %h %h %b", i, dout_a, dout_b, sample_valid, exp_a, exp_b, exp_v);
            end
        end
        transfer_reg = 1'b1;
        for (int i = 8; i <= 12; i++) begin
            step();
            transfer_reg = 1'b0;
            exp_v = (i == 12);
            checks++;
            if (sample_valid !== exp_v) begin
                errors++;
                $display("FAIL xfer_tick_clk%0d got v=%b want %b", i, sample_valid, exp_v);
            end
        end
        clock_divide = 8'h07;
        transfer_reg = 1'b1;
        step();
        transfer_reg = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL r8_clk%0d got v=%b want 0", i, sample_valid);
            end
        end
        clock_divide = 8'h01;
        for (int i = 6; i <= 8; i++) begin
            step();
            exp_v = (i != 7);
            checks++;
            if ({dout_a, sample_valid} !== {14'h2000, exp_v}) begin
                errors++;
                $display("FAIL shrink_clk%0d got a=%h v=%b want 2000 %b", i, dout_a, sample_valid, exp_v);
            end
        end
    endtask

    task automatic test_normal();
        logic exp_v;
        test_mode = 8'h00;
        adc_in_a = 14'h0123;
        adc_in_b = 14'h3210;
        for (int i = 0; i <= 4; i++) begin
            step();
            if (i == 2) adc_in_a = 14'h3FFF;
            if (i == 2) adc_in_b = 14'h0001;
            exp_v = (i == 2) || (i == 4);
            if (i == 2) begin
                exp_a = 14'h0123;
                exp_b = 14'h3210;
            end
            if (i == 4) begin
                exp_a = 14'h3FFF;
                exp_b = 14'h0001;
            end
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, exp_v}) begin
                errors++;
                $display("FAIL normal_clk%0d got a=%h b=%h v=%b want %h %h %b", i, dout_a, dout_b, sample_valid, exp_a, exp_b, exp_v);
            end
        end
        test_mode = 8'h0B;
        for (int i = 0; i <= 4; i++) begin
            step();
            exp_v = (i == 2) || (i == 4);
            if (exp_v) begin
                exp_a = 14'h0;
                exp_b = 14'h0;
            end
            checks++;
            if ({dout_a, dout_b, sample_valid} !== {exp_a, exp_b, exp_v}) begin
                errors++;
                $display("FAIL rsvd_clk%0d got a=%h b=%h v=%b want %h %h %b", i, dout_a, dout_b, sample_valid, exp_a, exp_b, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        test_mode = 8'h00;
        clock_divide = 8'h00;
        utp1 = '0;
        utp2 = '0;
        utp3 = '0;
        utp4 = '0;
        transfer_reg = 1'b0;
        adc_in_a = '0;
        adc_in_b = '0;
        exp_a = '0;
        exp_b = '0;
        test_reset();
        test_checker();
        test_user();
        test_pn();
        test_back_to_back();
        test_normal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
